slow_clk_monitor: RTL and testbench

Receiving end of the divided slow-clock interface. Takes a slow, asynchronous square wave (such as a divided core clock or an external step clock) into the clk domain and synchronizes it. Emits single-cycle edge pulses, measures period and high time in clk cycles, and reports lock and timeout status. Used to qualify slow-clock-driven logic and to verify divider output on the board.

---
 rtl/slow_clk_monitor.sv | 156 +++++++++++++++
 tb/tb_slow_clk_monitor.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/slow_clk_monitor.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : slow_clk_monitor
// Brief   : Synchronizes a slow asynchronous square wave, emits edge pulses,
//           measures period / high time and reports lock and timeout status.
// Revision: 1.0 - initial release
// ============================================================================
module slow_clk_monitor #(
  parameter int unsigned      SYNC_STAGES = 2,
  parameter int unsigned      CNT_W       = 32,
  parameter logic [CNT_W-1:0] TIMEOUT     = CNT_W'(1_000_000)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             clk_in_i,
  input  logic             clear_i,
  output logic             rise_pulse_o,
  output logic             fall_pulse_o,
  output logic [CNT_W-1:0] period_o,
  output logic [CNT_W-1:0] high_time_o,
  output logic             period_valid_o,
  output logic             locked_o,
  output logic             timeout_o
);

  localparam logic [0:0]       ST_WAIT_FIRST = 1'b0;
  localparam logic [0:0]       ST_MEASURE    = 1'b1;
  localparam logic [CNT_W-1:0] CNT_ONE       = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX       = {CNT_W{1'b1}};

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_w;
  logic                   prev_q;
  logic                   rise_q;
  logic                   fall_q;

  logic [0:0]             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0]       period_q, period_d;
  logic [CNT_W-1:0]       high_q, high_d;
  logic                   pv_q, pv_d;
  logic                   locked_q, locked_d;
  logic                   timeout_q, timeout_d;
  logic                   hi_done_q, hi_done_d;

  assign sync_w = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge resetn) begin : p_sync
    if (!resetn) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], clk_in_i};
      prev_q <= sync_w;
      rise_q <= sync_w & ~prev_q;
      fall_q <= ~sync_w & prev_q;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin : p_state_reg
    if (!resetn) begin
      state_q <= ST_WAIT_FIRST;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin : p_next_state
    state_d = state_q;
    if (clear_i) begin
      state_d = ST_WAIT_FIRST;
    end else begin
      case (state_q)
        ST_WAIT_FIRST: if (rise_q) state_d = ST_MEASURE;
        default:       if (!rise_q && (cnt_q == TIMEOUT)) state_d = ST_WAIT_FIRST;
      endcase
    end
  end

  always_comb begin : p_outputs
    period_d  = period_q;
    high_d    = high_q;
    pv_d      = 1'b0;
    locked_d  = locked_q;
    timeout_d = timeout_q;
    hi_done_d = hi_done_q;

    if (clear_i) begin
      cnt_d = '0;
    end else if (rise_q) begin
      cnt_d = CNT_ONE;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end

    if (clear_i) begin
      period_d  = '0;
      high_d    = '0;
      locked_d  = 1'b0;
      timeout_d = 1'b0;
      hi_done_d = 1'b1;
    end else if (rise_q) begin
      hi_done_d = 1'b0;
      // The first rise after WAIT_FIRST only starts the count.
      if (state_q == ST_MEASURE) begin
        period_d = cnt_q;
        pv_d     = 1'b1;
        locked_d = (cnt_q == period_q);
      end
    end else if (state_q == ST_MEASURE) begin
      if (fall_q && !hi_done_q) begin
        high_d    = cnt_q;
        hi_done_d = 1'b1;
      end
      if (cnt_q == TIMEOUT) begin
        timeout_d = 1'b1;
        locked_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin : p_data_reg
    if (!resetn) begin
      cnt_q     <= '0;
      period_q  <= '0;
      high_q    <= '0;
      pv_q      <= 1'b0;
      locked_q  <= 1'b0;
      timeout_q <= 1'b0;
      hi_done_q <= 1'b1;
    end else begin
      cnt_q     <= cnt_d;
      period_q  <= period_d;
      high_q    <= high_d;
      pv_q      <= pv_d;
      locked_q  <= locked_d;
      timeout_q <= timeout_d;
      hi_done_q <= hi_done_d;
    end
  end

  assign rise_pulse_o   = rise_q;
  assign fall_pulse_o   = fall_q;
  assign period_o       = period_q;
  assign high_time_o    = high_q;
  assign period_valid_o = pv_q;
  assign locked_o       = locked_q;
  assign timeout_o      = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_slow_clk_monitor.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_slow_clk_monitor
// Brief   : Self-checking bench for slow_clk_monitor with a timestamp model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_slow_clk_monitor;

  localparam int S  = 2;
  localparam int CW = 32;
  localparam int TO = 50;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          clk_in_i = 1'b0;
  logic          clear_i = 1'b0;
  logic          rise_pulse_o, fall_pulse_o, period_valid_o, locked_o, timeout_o;
  logic [CW-1:0] period_o, high_time_o;

  always #5 clk = ~clk;

  slow_clk_monitor #(
    .SYNC_STAGES(S),
    .CNT_W      (CW),
    .TIMEOUT    (32'd50)
  ) dut (
    .clk           (clk),
    .resetn        (resetn),
    .clk_in_i      (clk_in_i),
    .clear_i       (clear_i),
    .rise_pulse_o  (rise_pulse_o),
    .fall_pulse_o  (fall_pulse_o),
    .period_o      (period_o),
    .high_time_o   (high_time_o),
    .period_valid_o(period_valid_o),
    .locked_o      (locked_o),
    .timeout_o     (timeout_o)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: input history plus timestamp of the last processed rise.
  bit hist[$];
  bit m_rise, m_fall, m_pv, m_locked, m_timeout, meas, hi_taken;
  int m_period, m_high, k, p;

  int pv_per[$];
  bit pv_lock[$];
  int last_rise_k, to_k, first_rise, ph, hi, lo;
  bit to_prev, done;

  typedef struct {
    int hi;
    int lo;
    int reps;
    int exp_period;
    int exp_high;
    bit exp_locked;
  } vec_t;
  vec_t vecs[6];

  int exp_seq_per[6]  = '{10, 10, 10, 12, 14, 14};
  bit exp_seq_lock[6] = '{0, 1, 1, 0, 0, 1};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < S + 2; i++) hist.push_back(1'b0);
    m_rise = 0; m_fall = 0; m_pv = 0; m_locked = 0; m_timeout = 0;
    meas = 0; hi_taken = 0; m_period = 0; m_high = 0; p = 0;
  endtask

  task automatic model_edge(input bit cin, input bit clr);
    bit r, f;
    int el;
    r = m_rise;
    f = m_fall;
    k++;
    hist.push_front(cin);
    if (hist.size() > S + 2) void'(hist.pop_back());
    m_rise = hist[S] && !hist[S+1];
    m_fall = !hist[S] && hist[S+1];
    m_pv   = 0;
    el     = k - p;
    if (clr) begin
      meas = 0; m_period = 0; m_high = 0; m_locked = 0; m_timeout = 0;
    end else if (r) begin
      if (meas) begin
        m_locked = (el == m_period);
        m_period = el;
        m_pv     = 1;
      end
      meas = 1; p = k; hi_taken = 0;
    end else if (meas) begin
      if (f && !hi_taken) begin
        m_high = el; hi_taken = 1;
      end
      if (el == TO) begin
        m_timeout = 1; m_locked = 0; meas = 0;
      end
    end
  endtask

  task automatic compare_all();
    chk("rise_pulse",   64'(rise_pulse_o),   64'(m_rise));
    chk("fall_pulse",   64'(fall_pulse_o),   64'(m_fall));
    chk("period_valid", 64'(period_valid_o), 64'(m_pv));
    chk("period",       64'(period_o),       64'(m_period));
    chk("high_time",    64'(high_time_o),    64'(m_high));
    chk("locked",       64'(locked_o),       64'(m_locked));
    chk("timeout",      64'(timeout_o),      64'(m_timeout));
  endtask

  task automatic cycle(input bit cin, input bit clr);
    clk_in_i = cin;
    clear_i  = clr;
    @(posedge clk); #1;
    model_edge(cin, clr);
    compare_all();
    if (period_valid_o) begin
      pv_per.push_back(int'(period_o));
      pv_lock.push_back(locked_o);
    end
    if (rise_pulse_o) last_rise_k = k;
    if (timeout_o && !to_prev) to_k = k;
    to_prev = timeout_o;
  endtask

  task automatic reset_cycle();
    clk_in_i = 1'b0;
    clear_i  = 1'b0;
    @(posedge clk); #1;
    compare_all();
    to_prev = timeout_o;
  endtask

  task automatic wave(input int h, input int l, input int reps);
    for (int r = 0; r < reps; r++) begin
      for (int i = 0; i < h; i++) cycle(1'b1, 1'b0);
      for (int i = 0; i < l; i++) cycle(1'b0, 1'b0);
    end
  endtask

  task automatic pat_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      cycle((ph % 10) < 5, 1'b0);
      ph++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{5, 5, 4, 10, 5, 1};
    vecs[1] = '{3, 9, 4, 12, 3, 1};
    vecs[2] = '{7, 7, 4, 14, 7, 1};
    vecs[3] = '{2, 6, 4,  8, 2, 1};
    vecs[4] = '{1, 5, 4,  6, 1, 1};
    vecs[5] = '{4, 4, 2,  8, 4, 0};

    k = 0; to_prev = 0; last_rise_k = 0; to_k = 0; first_rise = 0;
    model_reset();
    for (int i = 0; i < 3; i++) reset_cycle();
    resetn = 1'b1;

    // First rise latency, then a 5/5 lock followed by a mixed 5/7 period and 7/7.
    for (int i = 1; i <= 5; i++) begin
      cycle(1'b1, 1'b0);
      if (rise_pulse_o && first_rise == 0) first_rise = i;
    end
    chk("first_rise_latency", 64'(first_rise), 64'd3);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0);
    wave(5, 5, 2);
    wave(5, 7, 1);
    wave(7, 7, 3);
    chk("seq_pv_count", 64'(pv_per.size()), 64'd6);
    for (int i = 0; i < 6; i++) begin
      if (i < pv_per.size()) begin
        chk("seq_period", 64'(pv_per[i]), 64'(exp_seq_per[i]));
        chk("seq_locked", 64'(pv_lock[i]), 64'(exp_seq_lock[i]));
      end
    end
    chk("seq_high_time", 64'(high_time_o), 64'd7);

    // Table of steady waveforms, each started from a clear.
    for (int v = 0; v < 6; v++) begin
      cycle(1'b0, 1'b1);
      wave(vecs[v].hi, vecs[v].lo, vecs[v].reps);
      chk("tbl_period",    64'(period_o),    64'(vecs[v].exp_period));
      chk("tbl_high_time", 64'(high_time_o), 64'(vecs[v].exp_high));
      chk("tbl_locked",    64'(locked_o),    64'(vecs[v].exp_locked));
      chk("tbl_timeout",   64'(timeout_o),   64'd0);
    end

    // Timeout while held low; sticky across a new rise until clear.
    cycle(1'b0, 1'b1);
    wave(5, 5, 3);
    chk("to_pre_locked", 64'(locked_o), 64'd1);
    to_k = 0;
    for (int i = 0; i < 60; i++) cycle(1'b0, 1'b0);
    chk("to_flag",        64'(timeout_o), 64'd1);
    chk("to_locked",      64'(locked_o),  64'd0);
    chk("to_period_hold", 64'(period_o),  64'd10);
    chk("to_delay",       64'(to_k - last_rise_k), 64'(TO + 1));
    wave(5, 5, 2);
    chk("to_sticky", 64'(timeout_o), 64'd1);
    cycle(1'b0, 1'b1);
    cycle(1'b0, 1'b0);
    chk("to_cleared", 64'(timeout_o), 64'd0);

    // Clear coinciding with a processed rise while locked.
    cycle(1'b0, 1'b1);
    wave(5, 5, 3);
    ph = 0; done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      if (rise_pulse_o && locked_o) begin
        cycle((ph % 10) < 5, 1'b1);
        done = 1;
      end else begin
        cycle((ph % 10) < 5, 1'b0);
      end
      ph++;
    end
    chk("clr_rise_hit", 64'(done),           64'd1);
    chk("clr_locked",   64'(locked_o),       64'd0);
    chk("clr_period",   64'(period_o),       64'd0);
    chk("clr_pv",       64'(period_valid_o), 64'd0);
    pv_per.delete(); pv_lock.delete();
    pat_cycles(15);
    chk("clr_pv_first_rise", 64'(pv_per.size()), 64'd0);
    pat_cycles(10);
    chk("clr_pv_second_rise", 64'(pv_per.size()), 64'd1);
    if (pv_per.size() > 0) chk("clr_new_period", 64'(pv_per[0]), 64'd10);

    // Asynchronous reset in the middle of a high phase.
    cycle(1'b0, 1'b1);
    wave(5, 5, 3);
    chk("rst_pre_locked", 64'(locked_o), 64'd1);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0);
    #2 resetn = 1'b0;
    #1;
    model_reset();
    compare_all();
    chk("rst_async_period", 64'(period_o), 64'd0);
    reset_cycle();
    reset_cycle();
    resetn = 1'b1;
    pv_per.delete(); pv_lock.delete();
    wave(5, 5, 1);
    chk("rst_first_rise_no_pv", 64'(pv_per.size()), 64'd0);
    wave(5, 5, 1);
    chk("rst_second_rise_pv", 64'(pv_per.size()), 64'd1);

    // Randomized waveforms with occasional long lows and clears.
    for (int s = 0; s < 120; s++) begin
      hi = int'($urandom_range(1, 12));
      lo = ($urandom_range(0, 7) == 0) ? int'($urandom_range(45, 70)) : int'($urandom_range(1, 12));
      for (int i = 0; i < hi; i++) cycle(1'b1, $urandom_range(0, 39) == 0);
      for (int i = 0; i < lo; i++) cycle(1'b0, $urandom_range(0, 39) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
